// File: rtl/store_buffer_ctrl_pkg.sv
// Shared types and constants for the posted store buffer.
package stb_pkg;

   // Store width encodings carried on funct3
   localparam logic [2:0] ST_SB = 3'b000;
   localparam logic [2:0] ST_SH = 3'b001;
   localparam logic [2:0] ST_SW = 3'b010;

   // One buffered store: word address, lane-aligned data, byte enables
   typedef struct packed {
      logic [31:2] addr;
      logic [31:0] wdata;
      logic [3:0]  bmask;
   } stb_entry_t;

endpackage

// File: rtl/store_buffer_ctrl_lane_align.sv
// Store lane alignment: moves rs2 data into its byte lanes, builds the
// byte-enable mask and flags illegal or misaligned requests.
module store_lane_align
   import stb_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_data,
   input  logic [2:0]  i_funct3,
   output logic        o_legal,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_bmask
);

   // Decode width, place data in lanes, check natural alignment
   always_comb begin
      o_legal = 1'b0;
      o_wdata = i_data;
      o_bmask = 4'b0000;
      case (i_funct3)
         ST_SB: begin
            o_legal = 1'b1;
            o_wdata = {24'h0, i_data[7:0]} << {i_addr_lo, 3'b000};
            o_bmask = 4'b0001 << i_addr_lo;
         end
         ST_SH: begin
            o_legal = ~i_addr_lo[0];
            o_wdata = i_addr_lo[1] ? {i_data[15:0], 16'h0} : {16'h0, i_data[15:0]};
            o_bmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         ST_SW: begin
            o_legal = (i_addr_lo == 2'b00);
            o_wdata = i_data;
            o_bmask = 4'b1111;
         end
         default: begin
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted store buffer between MEM and the data-memory write port.
// In-order FIFO drain with valid/ready, plus a load hazard compare.
// Optional macro STB_FWD_EN adds store-to-load byte forwarding; the
// hazard then fires only for load bytes no pending store covers.
module store_buffer_ctrl
   import stb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_st_vld,
   input  logic [31:0] i_st_addr,
   input  logic [31:0] i_st_data,
   input  logic [2:0]  i_st_funct3,
   output logic        o_st_rdy,
   input  logic        i_ld_vld,
   input  logic [31:0] i_ld_addr,
   output logic        o_ld_hazard,
`ifdef STB_FWD_EN
   input  logic [3:0]  i_ld_bmask,
   output logic [31:0] o_fwd_data,
   output logic [3:0]  o_fwd_bmask,
`endif
   output logic        o_mem_vld,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_bmask,
   input  logic        i_mem_rdy,
   output logic        o_full,
   output logic        o_empty,
   output logic        o_err_misalign
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   stb_entry_t       mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             al_legal;
   logic [31:0]      al_wdata;
   logic [3:0]       al_bmask;
   logic             push_hs, push, pop;
   logic             any_match;
   logic [PTR_W-1:0] idx;
   logic             unused_ld_lo;
`ifdef STB_FWD_EN
   logic [31:0]      fwd_data;
   logic [3:0]       fwd_bmask;
`endif

   store_lane_align u_align (
      .i_addr_lo (i_st_addr[1:0]),
      .i_data    (i_st_data),
      .i_funct3  (i_st_funct3),
      .o_legal   (al_legal),
      .o_wdata   (al_wdata),
      .o_bmask   (al_bmask)
   );

   // Full blocks the handshake outright, even if the head pops this cycle
   assign o_full         = (cnt_q == FULL_CNT);
   assign o_empty        = (cnt_q == '0);
   assign o_st_rdy       = ~o_full;
   assign push_hs        = i_st_vld & o_st_rdy;
   assign push           = push_hs & al_legal;
   assign pop            = ~o_empty & i_mem_rdy;

   assign o_mem_vld      = ~o_empty;
   assign o_mem_addr     = {mem_q[rd_ptr_q].addr, 2'b00};
   assign o_mem_wdata    = mem_q[rd_ptr_q].wdata;
   assign o_mem_bmask    = mem_q[rd_ptr_q].bmask;
   assign o_err_misalign = err_q;
   assign unused_ld_lo   = ^i_ld_addr[1:0];

   // Next-state for pointers, occupancy, entry valid bits and error pulse
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      cnt_d    = cnt_q;
      err_d    = push_hs & ~al_legal;
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state; reset discards every pending entry at once
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vld_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
      end
   end

   // Entry payload storage; only meaningful where the valid bit is set
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{addr: i_st_addr[31:2], wdata: al_wdata, bmask: al_bmask};
      end
   end

   // Walk entries oldest to youngest so the youngest match wins each lane
   always_comb begin
      any_match = 1'b0;
      idx       = rd_ptr_q;
`ifdef STB_FWD_EN
      fwd_data  = '0;
      fwd_bmask = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PTR_W'(k);
         if (vld_q[idx] && (mem_q[idx].addr == i_ld_addr[31:2])) begin
            any_match = 1'b1;
`ifdef STB_FWD_EN
            for (int b = 0; b < 4; b++) begin
               if (mem_q[idx].bmask[b]) begin
                  fwd_data[8*b +: 8] = mem_q[idx].wdata[8*b +: 8];
               end
            end
            fwd_bmask = fwd_bmask | mem_q[idx].bmask;
`endif
         end
      end
   end

`ifdef STB_FWD_EN
   assign o_fwd_data  = fwd_data;
   assign o_fwd_bmask = fwd_bmask;
   assign o_ld_hazard = i_ld_vld & any_match & (|(i_ld_bmask & ~fwd_bmask));
`else
   assign o_ld_hazard = i_ld_vld & any_match;
`endif

endmodule
